// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW + 1R single-clock SRAM with masked writes,
// defined collision behaviour, read strobes and post-reset zero fill.
module sram_1rw1r_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int MASK_GRAN      = 8,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = 0,
    parameter int INIT_ON_RESET  = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              init_done,
    input  logic                              csb0,
    input  logic                              web0,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0]   wmask0,
    input  logic [ADDR_WIDTH-1:0]             addr0,
    input  logic [DATA_WIDTH-1:0]             din0,
    output logic [DATA_WIDTH-1:0]             dout0,
    output logic                              dout0_valid,
    input  logic                              csb1,
    input  logic [ADDR_WIDTH-1:0]             addr1,
    output logic [DATA_WIDTH-1:0]             dout1,
    output logic                              dout1_valid,
    output logic                              collision
);

    localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_READY;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
    logic                    init_done_q, init_done_d;
    logic                    fill_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            fill_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        init_done_d = init_done_q;
        fill_we     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                fill_we = 1'b1;
                fill_d  = fill_q + 1'b1;
                if (fill_q == LAST_ADDR) begin
                    state_d     = S_READY;
                    init_done_d = 1'b1;
                end
            end
            S_READY: begin
                init_done_d = 1'b1;
            end
        endcase
    end

    assign init_done = init_done_q;

    // Requests are only honoured once the fill has finished.
    logic ready, p0_rd, p0_wr, p1_rd, coll;
    assign ready = (state_q == S_READY);
    assign p0_rd = ready & ~csb0 & web0;
    assign p0_wr = ready & ~csb0 & ~web0;
    assign p1_rd = ready & ~csb1;
    assign coll  = p0_wr & p1_rd & (addr0 == addr1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd1_word;

    always_comb begin
        wr_word = mem[addr0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                wr_word[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    assign rd1_word = ((COLLISION_MODE != 0) && coll) ? wr_word : mem[addr1];

    // Array is deliberately not reset; the fill FSM clears it instead.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_q] <= '0;
        end else if (p0_wr) begin
            mem[addr0] <= wr_word;
        end
    end

    logic [DATA_WIDTH-1:0] s1_d0_q, s1_d1_q;
    logic                  s1_v0_q, s1_v1_q, s1_c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_d0_q <= '0;
            s1_d1_q <= '0;
            s1_v0_q <= 1'b0;
            s1_v1_q <= 1'b0;
            s1_c_q  <= 1'b0;
        end else begin
            s1_v0_q <= p0_rd;
            s1_v1_q <= p1_rd;
            s1_c_q  <= coll;
            if (p0_rd) s1_d0_q <= mem[addr0];
            if (p1_rd) s1_d1_q <= rd1_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_d0_q, s2_d1_q;
            logic                  s2_v0_q, s2_v1_q, s2_c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_d0_q <= '0;
                    s2_d1_q <= '0;
                    s2_v0_q <= 1'b0;
                    s2_v1_q <= 1'b0;
                    s2_c_q  <= 1'b0;
                end else begin
                    s2_v0_q <= s1_v0_q;
                    s2_v1_q <= s1_v1_q;
                    s2_c_q  <= s1_c_q;
                    if (s1_v0_q) s2_d0_q <= s1_d0_q;
                    if (s1_v1_q) s2_d1_q <= s1_d1_q;
                end
            end

            assign dout0       = s2_d0_q;
            assign dout0_valid = s2_v0_q;
            assign dout1       = s2_d1_q;
            assign dout1_valid = s2_v1_q;
            assign collision   = s2_c_q;
        end else begin : g_lat1
            assign dout0       = s1_d0_q;
            assign dout0_valid = s1_v0_q;
            assign dout1       = s1_d1_q;
            assign dout1_valid = s1_v1_q;
            assign collision   = s1_c_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench: one stimulus stream drives a latency-1/old-data
// instance (A) and a latency-2/write-through instance (B).
module tb_sram_1rw1r_param;

    typedef struct {
        logic [31:0] d;
        logic        c;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0;

    logic        a_init, a_v0, a_v1, a_coll;
    logic [31:0] a_d0, a_d1;
    logic        b_init, b_v0, b_v1, b_coll;
    logic [31:0] b_d0, b_d1;

    int   cyc = 0;
    int   vectors = 0;
    int   miss = 0;
    exp_t q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1rw1r_param u_a (
        .clk(clk), .rst_n(rst_n), .init_done(a_init),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(a_d0), .dout0_valid(a_v0),
        .csb1(csb1), .addr1(addr1), .dout1(a_d1),
        .dout1_valid(a_v1), .collision(a_coll)
    );

    sram_1rw1r_param #(.RD_LATENCY(2), .COLLISION_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .init_done(b_init),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(b_d0), .dout0_valid(b_v0),
        .csb1(csb1), .addr1(addr1), .dout1(b_d1),
        .dout1_valid(b_v1), .collision(b_coll)
    );

    function automatic string qn(input int k);
        case (k)
            0: return "A.port0";
            1: return "A.port1";
            2: return "B.port0";
            default: return "B.port1";
        endcase
    endfunction

    task automatic mon(input int k, input logic v, input logic [31:0] d, input logic c);
        exp_t e;
        if (v) begin
            vectors++;
            if (q[k].size() == 0) begin
                miss++;
                $display("FAIL %s unexpected_valid: data=%h coll=%b cyc=%0d, none expected",
                         qn(k), d, c, cyc);
            end else begin
                e = q[k].pop_front();
                if (d !== e.d || c !== e.c || cyc != e.t) begin
                    miss++;
                    $display("FAIL %s read: got data=%h coll=%b cyc=%0d, want data=%h coll=%b cyc=%0d",
                             qn(k), d, c, cyc, e.d, e.c, e.t);
                end
            end
        end else if (c !== 1'b0) begin
            vectors++;
            miss++;
            $display("FAIL %s stray_collision: got coll=%b without valid, want 0", qn(k), c);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon(0, a_v0, a_d0, 1'b0);
            mon(1, a_v1, a_d1, a_coll);
            mon(2, b_v0, b_d0, 1'b0);
            mon(3, b_v1, b_d1, b_coll);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1;
        web0 = 1'b1;
        csb1 = 1'b1;
        tick();
    endtask

    task automatic op(input logic c0, input logic w0, input logic [3:0] m,
                      input logic [8:0] a0, input logic [31:0] di,
                      input logic c1, input logic [8:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1a,
                      input logic [31:0] e1b, input logic ec);
        csb0   = c0;
        web0   = w0;
        wmask0 = m;
        addr0  = a0;
        din0   = di;
        csb1   = c1;
        addr1  = a1;
        if (!c0 && w0) begin
            q[0].push_back('{e0, 1'b0, cyc + 1});
            q[2].push_back('{e0, 1'b0, cyc + 2});
        end
        if (!c1) begin
            q[1].push_back('{e1a, ec, cyc + 1});
            q[3].push_back('{e1b, ec, cyc + 2});
        end
        tick();
    endtask

    task automatic chk(input string nm, input logic ok, input logic [63:0] got,
                       input logic [63:0] want);
        vectors++;
        if (!ok) begin
            miss++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string nm);
        logic [7:0] o;
        o = {a_init, a_v0, a_v1, a_coll, b_init, b_v0, b_v1, b_coll};
        chk(nm, o == 8'h00 && a_d0 == 0 && a_d1 == 0 && b_d0 == 0 && b_d1 == 0,
            {24'd0, o, a_d0 | a_d1 | b_d0 | b_d1}, 64'd0);
    endtask

    int na, nb;

    initial begin
        rst_n  = 1'b0;
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = 4'hF;
        addr0  = 9'h1FF;
        din0   = 32'hFFFF_FFFF;
        csb1   = 1'b0;
        addr1  = 9'h1FF;
        #3;
        chk_zero("reset_outputs");

        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) tick();
        chk("init_low_at_100", !a_init && !b_init, {62'd0, a_init, b_init}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_init_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        na = 0;
        nb = 0;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (a_init && na == 0) na = n;
            if (b_init && nb == 0) nb = n;
            if (na != 0 && nb != 0) break;
        end
        csb0 = 1'b1;
        csb1 = 1'b1;
        chk("init_cycles_A", na == 512, 64'(na), 64'd512);
        chk("init_cycles_B", nb == 512, 64'(nb), 64'd512);

        op(0, 1, 4'h0, 9'h1FF, 0, 1, 0, 32'h0, 0, 0, 0);

        op(0, 0, 4'hF, 9'h010, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
        op(0, 0, 4'b0101, 9'h010, 32'h11223344, 1, 0, 0, 0, 0, 0);
        op(0, 1, 4'h0, 9'h010, 0, 1, 0, 32'hDE22BE44, 0, 0, 0);

        for (int i = 0; i < 4; i++)
            op(0, 0, 4'hF, 9'(i), 32'(8'hA0 + i), 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            op(1, 1, 4'h0, 0, 0, 0, 9'(i), 0, 32'(8'hA0 + i), 32'(8'hA0 + i), 0);

        op(0, 1, 4'h0, 9'h002, 0, 0, 9'h002, 32'hA2, 32'hA2, 32'hA2, 0);

        op(0, 0, 4'b0011, 9'h020, 32'hCAFEF00D, 0, 9'h020,
           0, 32'h0000_0000, 32'h0000_F00D, 1);
        op(0, 1, 4'h0, 9'h020, 0, 1, 0, 32'h0000_F00D, 0, 0, 0);

        op(0, 0, 4'hF, 9'h030, 32'h12345678, 0, 9'h010,
           0, 32'hDE22BE44, 32'hDE22BE44, 0);
        op(0, 0, 4'h0, 9'h030, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        op(0, 1, 4'h0, 9'h030, 0, 1, 0, 32'h12345678, 0, 0, 0);

        op(0, 0, 4'hF, 9'h005, 32'h55, 1, 0, 0, 0, 0, 0);
        op(0, 1, 4'h0, 9'h005, 0, 1, 0, 32'h55, 0, 0, 0);
        repeat (3) idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("hold_idle", a_d0 == 32'h55 && !a_v0 && b_d0 == 32'h55 && !b_v0,
                {a_d0, b_d0}, {32'h55, 32'h55});
        end
        op(0, 0, 4'hF, 9'h006, 32'h66, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_after_write", a_d0 == 32'h55 && !a_v0 && b_d0 == 32'h55 && !b_v0,
                {a_d0, b_d0}, {32'h55, 32'h55});
            idle();
        end

        repeat (4) idle();
        for (int k = 0; k < 4; k++)
            chk({"drained_", qn(k)}, q[k].size() == 0, 64'(q[k].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
